cache_ctrl: RTL
===============

# cache_ctrl

Direct-mapped, write-through, read-allocate cache controller that sequences the cache data RAM (`dataRam`) between a CPU port and a backing-memory port. It holds the tag and valid arrays and decides hit or miss. It also drives the data RAM's `index`/`data`/`we`/`deload` inputs and runs refills, write-throughs and a full-cache flush. Lines are one word wide.

## Interface
- `ADDR_LENGTH`, 32, CPU/memory word-address width
- `INDEX_LENGTH`, 4, line index width; tag width is ADDR_LENGTH-INDEX_LENGTH
- `DATA_LENGTH`, 32, word width
- `CACHE_LINES`, 16, number of lines; must equal 2**INDEX_LENGTH
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `cpu_req_i`  in  1  CPU request, sampled only in IDLE
- `cpu_we_i`  in  1  1 = write, 0 = read
- `cpu_addr_i`  in  ADDR_LENGTH  word address; the low INDEX_LENGTH bits are the index, the rest is the tag
- `cpu_wdata_i`  in  DATA_LENGTH  write data
- `cpu_ready_o`  out  1  one-cycle completion pulse
- `cpu_rdata_o`  out  DATA_LENGTH  read data, valid while cpu_ready_o=1
- `flush_i`  in  1  invalidate-all request, sampled only in IDLE
- `flush_done_o`  out  1  one-cycle pulse on the last flush cycle
- `mem_req_o`  out  1  memory request, held until acknowledged
- `mem_we_o`  out  1  memory write strobe
- `mem_addr_o`  out  ADDR_LENGTH  latched CPU address
- `mem_wdata_o`  out  DATA_LENGTH  latched write data
- `mem_ack_i`  in  1  memory acknowledge; read data is valid in the same cycle
- `mem_rdata_i`  in  DATA_LENGTH  memory read data
- `ram_index_o`  out  INDEX_LENGTH  data RAM index
- `ram_data_o`  out  DATA_LENGTH  data RAM write data
- `ram_we_o`  out  1  data RAM write enable
- `ram_deload_o`  out  1  data RAM line clear
- `ram_data_i`  in  DATA_LENGTH  data RAM read data (combinational read)

## Operation
- States: IDLE, LOOKUP, REFILL, WRITE, FLUSH.
- **IDLE**
  - If `flush_i`=1, go to FLUSH with the flush counter at 0. Flush wins when `flush_i` and `cpu_req_i` are both high; the request is not latched.
  - Otherwise, if `cpu_req_i`=1, latch address, write-enable and write data, then go to LOOKUP.
- **LOOKUP**
  - `ram_index_o` = latched index.
  - Hit = valid[index] and tag[index] == latched tag.
  - Read hit: `cpu_rdata_o`=`ram_data_i`, `cpu_ready_o`=1, go to IDLE.
  - Read miss: go to REFILL.
  - Write hit: `ram_we_o`=1 and `ram_data_o`=write data this cycle, then go to WRITE.
  - Write miss: go to WRITE with no allocation.
- **REFILL**
  - `mem_req_o`=1, `mem_we_o`=0 until `mem_ack_i` is seen.
  - On ack, in the same cycle: `ram_we_o`=1, `ram_data_o`=`mem_rdata_i`, `cpu_rdata_o`=`mem_rdata_i`, `cpu_ready_o`=1.
  - At the ack edge, write tag[index] and set valid[index]=1, then go to IDLE.
- **WRITE**
  - `mem_req_o`=1, `mem_we_o`=1 until `mem_ack_i` is seen.
  - On ack: `cpu_ready_o`=1, go to IDLE.
- **FLUSH**
  - Each cycle: `ram_index_o`=counter, `ram_deload_o`=1, valid[counter] cleared at the edge.
  - The counter increments and wraps; at counter==CACHE_LINES-1, `flush_done_o`=1 and the next state is IDLE.
- `mem_ack_i` is ignored outside REFILL and WRITE.
- `cpu_req_i` is ignored outside IDLE; a request held through a flush is serviced afterwards.
- Outside the cycles listed above, `ram_we_o` and `ram_deload_o` are 0.
- `ram_index_o` follows the latched index, or the counter in FLUSH.
- `cpu_rdata_o` is 0 whenever `cpu_ready_o`=0.

## Timing
- Request sampled at edge N; LOOKUP occupies cycle N+1.
- Read hit: `cpu_ready_o` high in cycle N+1 (1-cycle latency).
- Miss or write: `mem_req_o` rises in cycle N+2. `cpu_ready_o` is high in the cycle `mem_ack_i` is high, with minimum latency 2.
- Flush: sampled at edge N; cycles N+1..N+CACHE_LINES clear indices 0..CACHE_LINES-1; IDLE at N+CACHE_LINES+1.
- Reset values:
  - state IDLE, all valid bits 0, flush counter 0
  - all outputs 0, latched address and data 0
- Reset during REFILL, WRITE or FLUSH:
  - The memory transaction is abandoned and `mem_req_o`=0 from the next cycle.
  - A late `mem_ack_i` is ignored.
  - The data RAM is not written.
  - All lines become invalid, so a partial flush still yields an empty cache.

## Configuration
- `CACHE_STATS_EN`: when defined, adds outputs `hit_count_o` and `miss_count_o` (16 bits each).
  - Each counter increments on the LOOKUP cycle of a hit or miss (reads and writes), saturates at 0xFFFF, and clears on `rst`.
- Without the macro, both ports exist and are tied to 0, and no counter logic is built.

## Test plan
- Read miss then hit: read 0x13 with memory returning 0xDEADBEEF after 3 wait cycles.
  - First access: `mem_req_o` is high for 4 cycles, then `cpu_ready_o` with rdata 0xDEADBEEF, and RAM index 3 is written.
  - Re-read 0x13: `cpu_ready_o` one cycle after the request, with no `mem_req_o`.
- Conflict: after 0x13 is cached, read 0x23 (same index 3, tag 2) → miss and refill; then read 0x13 → miss again.
- Write hit at 0x13 with 0x12345678: `ram_we_o` pulses in LOOKUP; memory write carries addr 0x13 and data 0x12345678; a following read hits and returns 0x12345678.
- Write miss at 0x40: memory write only, `ram_we_o` never asserted; a following read of 0x40 misses.
- Flush asserted together with a read of 0x13:
  - 16 `ram_deload_o` cycles over indices 0..15, with `flush_done_o` on index 15.
  - Then the held read is serviced and misses.
- `rst` raised during a REFILL wait → `mem_req_o` low next cycle; a later ack produces no `cpu_ready_o`; a read of any address misses. With `CACHE_STATS_EN` defined, both counters read 0.

Source files
------------

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, read-allocate cache controller sequencing an external one-word-per-line data RAM.
// Optional macro CACHE_STATS_EN builds saturating hit/miss counters behind hit_count_o/miss_count_o.
module cache_ctrl #(
    parameter int ADDR_LENGTH  = 32,
    parameter int INDEX_LENGTH = 4,
    parameter int DATA_LENGTH  = 32,
    parameter int CACHE_LINES  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_req_i,
    input  logic                    cpu_we_i,
    input  logic [ADDR_LENGTH-1:0]  cpu_addr_i,
    input  logic [DATA_LENGTH-1:0]  cpu_wdata_i,
    output logic                    cpu_ready_o,
    output logic [DATA_LENGTH-1:0]  cpu_rdata_o,
    input  logic                    flush_i,
    output logic                    flush_done_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [ADDR_LENGTH-1:0]  mem_addr_o,
    output logic [DATA_LENGTH-1:0]  mem_wdata_o,
    input  logic                    mem_ack_i,
    input  logic [DATA_LENGTH-1:0]  mem_rdata_i,
    output logic [INDEX_LENGTH-1:0] ram_index_o,
    output logic [DATA_LENGTH-1:0]  ram_data_o,
    output logic                    ram_we_o,
    output logic                    ram_deload_o,
    input  logic [DATA_LENGTH-1:0]  ram_data_i,
    output logic [15:0]             hit_count_o,
    output logic [15:0]             miss_count_o
);
    localparam int TAG_LENGTH = ADDR_LENGTH - INDEX_LENGTH;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_REFILL, S_WRITE, S_FLUSH} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_LENGTH-1:0]  r_addr;
    logic                    r_we;
    logic [DATA_LENGTH-1:0]  r_wdata;
    logic [CACHE_LINES-1:0]  r_valid;
    logic [TAG_LENGTH-1:0]   r_tag [CACHE_LINES];
    logic [INDEX_LENGTH-1:0] r_cnt;

    logic [INDEX_LENGTH-1:0] w_index;
    logic [TAG_LENGTH-1:0]   w_tag;
    logic                    w_hit;
    logic                    w_ack;
    logic                    w_last;

    assign w_index = r_addr[INDEX_LENGTH-1:0];
    assign w_tag   = r_addr[ADDR_LENGTH-1:INDEX_LENGTH];
    assign w_hit   = r_valid[w_index] && (r_tag[w_index] == w_tag);
    // An ack arriving while reset is asserted must not complete the abandoned transaction.
    assign w_ack   = mem_ack_i && !rst;
    assign w_last  = (r_cnt == INDEX_LENGTH'(CACHE_LINES - 1));

    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_valid <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (flush_i) begin
                        r_cnt <= '0;
                    end else if (cpu_req_i) begin
                        r_addr  <= cpu_addr_i;
                        r_we    <= cpu_we_i;
                        r_wdata <= cpu_wdata_i;
                    end
                end
                S_REFILL: if (w_ack) r_valid[w_index] <= 1'b1;
                S_FLUSH: begin
                    r_valid[r_cnt] <= 1'b0;
                    r_cnt          <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Tags need no reset: a line's tag is only trusted while its valid bit is set.
    always_ff @(posedge clk) begin
        if (r_state == S_REFILL && w_ack) r_tag[w_index] <= w_tag;
    end

    always_comb begin
        w_next       = r_state;
        cpu_ready_o  = 1'b0;
        cpu_rdata_o  = '0;
        flush_done_o = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        ram_index_o  = w_index;
        ram_data_o   = '0;
        ram_we_o     = 1'b0;
        ram_deload_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (flush_i)        w_next = S_FLUSH;
                else if (cpu_req_i) w_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (r_we) begin
                    if (w_hit) begin
                        ram_we_o   = 1'b1;
                        ram_data_o = r_wdata;
                    end
                    w_next = S_WRITE;
                end else if (w_hit) begin
                    cpu_ready_o = 1'b1;
                    cpu_rdata_o = ram_data_i;
                    w_next      = S_IDLE;
                end else begin
                    w_next = S_REFILL;
                end
            end
            S_REFILL: begin
                mem_req_o = 1'b1;
                if (w_ack) begin
                    ram_we_o    = 1'b1;
                    ram_data_o  = mem_rdata_i;
                    cpu_ready_o = 1'b1;
                    cpu_rdata_o = mem_rdata_i;
                    w_next      = S_IDLE;
                end
            end
            S_WRITE: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                if (w_ack) begin
                    cpu_ready_o = 1'b1;
                    w_next      = S_IDLE;
                end
            end
            S_FLUSH: begin
                ram_index_o  = r_cnt;
                ram_deload_o = 1'b1;
                if (w_last) begin
                    flush_done_o = 1'b1;
                    w_next       = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

`ifdef CACHE_STATS_EN
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == S_LOOKUP) begin
            if (w_hit) begin
                if (r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
            end else begin
                if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
            end
        end
    end

    assign hit_count_o  = r_hit_cnt;
    assign miss_count_o = r_miss_cnt;
`else
    assign hit_count_o  = '0;
    assign miss_count_o = '0;
`endif

endmodule
